div_issue_ctrl: RTL and testbench
=================================

# div_issue_ctrl

Sequencer that sits directly upstream of the 32-bit signed divider core. It accepts a divide request over a valid/ready handshake and holds the operands stable for the whole operation. It pulses the core's `ctrl_DIV` start, counts the core's fixed latency, then captures quotient, remainder and divide-by-zero flag into a response register with its own valid/ready handshake. A zero divisor is short-circuited without starting the core.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width.
- `DIV_LATENCY`, 33, cycles from the core's start pulse until its outputs are final.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_divid`  in  WIDTH  dividend, two's complement.
- `req_divis`  in  WIDTH  divisor, two's complement.
- `core_start`  out  1  one-cycle pulse to the core's `ctrl_DIV`.
- `core_divid`  out  WIDTH  latched dividend to the core.
- `core_divis`  out  WIDTH  latched divisor to the core.
- `core_quot`  in  WIDTH  quotient from the core.
- `core_rem`  in  WIDTH  remainder from the core.
- `core_except`  in  1  core's divide-by-zero flag.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_quot`  out  WIDTH  registered quotient.
- `rsp_rem`  out  WIDTH  registered remainder.
- `rsp_except`  out  1  registered exception.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, START, WAIT, DONE.
- IDLE:
  - `req_valid` high with divisor != 0: latch both operands, go to START.
  - `req_valid` high with divisor == 0: load response quot=0, rem=0, except=1, go to DONE.
- START: `core_start`=1 for exactly this cycle. Load the latency counter with DIV_LATENCY-1. Go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle the counter reads 0, capture `core_quot`, `core_rem` and `core_except` into the response registers and go to DONE.
- DONE: `rsp_valid`=1. On `rsp_valid && rsp_ready`, go to IDLE.
- `core_divid` and `core_divis` hold the latched values from accept until the next accept. They never change during START or WAIT.
- The block does no arithmetic on results. Sign handling belongs to the core and results pass through bit-exact.
- Requests arriving while not in IDLE are not accepted, because `req_ready`=0. The requester must hold them.

## Timing
- Accept at the rising edge ending cycle T, when `req_valid && req_ready`.
- Nonzero divisor:
  - START in cycle T+1.
  - WAIT in cycles T+2 through T+1+DIV_LATENCY.
  - Capture at the edge ending T+1+DIV_LATENCY.
  - `rsp_valid` from cycle T+2+DIV_LATENCY, i.e. 35 cycles after accept at default.
- Zero divisor: `rsp_valid` from cycle T+1. `core_start` never asserts.
- Backpressure: while `rsp_valid`=1 and `rsp_ready`=0, all `rsp_*` outputs hold stable indefinitely.
- `req_ready` is asserted in IDLE only, including the cycle after a response handshake. The minimum spacing between accepts is therefore latency+1 cycles.
- Reset (synchronous, any state, including mid-WAIT):
  - Next state is IDLE.
  - `core_start`=0, `rsp_valid`=0, `busy`=0.
  - `rsp_quot`, `rsp_rem`, `rsp_except`, `core_divid`, `core_divis` and the counter are all 0.
  - `req_ready` is 1 in the first cycle after reset.
- The core needs no separate reset: its internal counter restarts on the next `core_start`.
- `reset` asserted together with `req_valid`: reset wins and nothing is accepted.

## Structure
- Package `div_seq_pkg`: state enum `div_seq_state_t` {IDLE, START, WAIT, DONE}, and the constant `DIV_LATENCY_DEFAULT`=33.
- One sub-module, `lat_counter`:
  - Loadable 6-bit down-counter with synchronous reset, load and enable.
  - Outputs a `zero` flag.
  - Reusable for the multiplier sequencer.
- All other logic (FSM, operand latches, response registers) lives in the top module.

## Test plan
- 100 / 7, `rsp_ready`=1: `core_start` pulses once at T+1; `rsp_valid` at T+35 with quot=14, rem=2, except=0; `busy` returns to 0 one cycle later.
- -100 / 7: `rsp_quot`=32'hFFFFFFF2 (-14), except=0, same 35-cycle latency; `core_divid` is stable at 32'hFFFFFF9C throughout WAIT.
- 5 / 0: `rsp_valid` at T+1 with quot=0, rem=0, except=1; `core_start` never asserts.
- Backpressure: 100 / 7 completes with `rsp_ready`=0 for 10 cycles; outputs stay constant; handshake on cycle 11 returns to IDLE.
- Second request held on `req_valid` during WAIT: `req_ready` stays 0 until IDLE; the request is accepted on the first IDLE cycle and its operands appear on `core_divid`/`core_divis` the next cycle.
- Reset asserted in WAIT cycle 10: next cycle is IDLE with `rsp_valid`=0 and all registers 0; a following 100 / 7 completes normally in 35 cycles.

Source files
------------

// File: rtl/div_issue_ctrl_pkg.sv
// Shared types for the divider/multiplier issue sequencers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } div_seq_state_t;

  // Fixed latency of the signed divider core, start pulse to final outputs.
  localparam int DIV_LATENCY_DEFAULT = 33;

  // Width of the shared latency counter; large enough for DIV_LATENCY-1.
  localparam int LAT_CNT_W = 6;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Request / core / response signal bundle of the divider issue sequencer.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready handshakes.
// slave  = sequencer side; master = environment (requester, core, consumer).
interface div_issue_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_divid;
  logic [WIDTH-1:0] req_divis;

  logic             core_start;
  logic [WIDTH-1:0] core_divid;
  logic [WIDTH-1:0] core_divis;
  logic [WIDTH-1:0] core_quot;
  logic [WIDTH-1:0] core_rem;
  logic             core_except;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_quot;
  logic [WIDTH-1:0] rsp_rem;
  logic             rsp_except;

  logic             busy;

  modport slave (
    input  req_valid, req_divid, req_divis,
    input  core_quot, core_rem, core_except,
    input  rsp_ready,
    output req_ready,
    output core_start, core_divid, core_divis,
    output rsp_valid, rsp_quot, rsp_rem, rsp_except,
    output busy
  );

  modport master (
    output req_valid, req_divid, req_divis,
    output core_quot, core_rem, core_except,
    output rsp_ready,
    input  req_ready,
    input  core_start, core_divid, core_divis,
    input  rsp_valid, rsp_quot, rsp_rem, rsp_except,
    input  busy
  );
endinterface

// File: rtl/div_issue_ctrl_lat_counter.sv
// Loadable saturating down-counter used to time fixed-latency arithmetic cores.
// Latency: load/decrement visible the cycle after the enabling edge.
// Backpressure: none; holds at zero once reached.
// Ports: clk, reset (sync, active-high), load_i/load_val_i, en_i, zero_o.
module lat_counter
  import div_seq_pkg::*;
#(
  parameter int W = LAT_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue sequencer in front of the signed divider core: latch operands, pulse start,
// time the core, register the result. Latency: accept to rsp_valid = DIV_LATENCY+2
// cycles (1 cycle for a zero divisor). Backpressure: req_ready only in IDLE; rsp_* hold
// until rsp_ready.
// Ports: clk, reset (sync, active-high), bus (slave side of div_issue_ctrl_if).
module div_issue_ctrl
  import div_seq_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  div_issue_ctrl_if.slave        bus
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(DIV_LATENCY - 1);

  div_seq_state_t   state_q;
  logic             req_ready_q;
  logic             busy_q;
  logic             core_start_q;
  logic [WIDTH-1:0] divid_q;
  logic [WIDTH-1:0] divis_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_quot_q;
  logic [WIDTH-1:0] rsp_rem_q;
  logic             rsp_except_q;

  logic cnt_zero;

  // START loads DIV_LATENCY-1 so the counter reaches zero in the last WAIT cycle,
  // exactly DIV_LATENCY cycles after the start pulse.
  lat_counter #(
    .W (LAT_CNT_W)
  ) u_lat_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (state_q == START),
    .en_i       (state_q == WAIT),
    .load_val_i (LAT_LOAD),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      core_start_q <= 1'b0;
      divid_q      <= '0;
      divis_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_quot_q   <= '0;
      rsp_rem_q    <= '0;
      rsp_except_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (bus.req_divis != '0) begin
              divid_q      <= bus.req_divid;
              divis_q      <= bus.req_divis;
              core_start_q <= 1'b1;
              state_q      <= START;
            end else begin
              // Divide by zero never reaches the core; answer immediately.
              rsp_quot_q   <= '0;
              rsp_rem_q    <= '0;
              rsp_except_q <= 1'b1;
              rsp_valid_q  <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        START: begin
          core_start_q <= 1'b0;
          state_q      <= WAIT;
        end
        WAIT: begin
          if (cnt_zero) begin
            rsp_quot_q   <= bus.core_quot;
            rsp_rem_q    <= bus.core_rem;
            rsp_except_q <= bus.core_except;
            rsp_valid_q  <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.busy       = busy_q;
  assign bus.core_start = core_start_q;
  assign bus.core_divid = divid_q;
  assign bus.core_divis = divis_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_quot   = rsp_quot_q;
  assign bus.rsp_rem    = rsp_rem_q;
  assign bus.rsp_except = rsp_except_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: vector table, hand-written corner
// sequences and randomized transactions against a magnitude/sign reference model.
// Includes a behavioural divider core that only shows final results DIV_LATENCY cycles after start.
module tb_div_issue_ctrl;

  localparam int LAT = 33;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_issue_ctrl_if #(.WIDTH(32)) dif ();

  div_issue_ctrl #(
    .WIDTH       (32),
    .DIV_LATENCY (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  // ---------------- behavioural divider core ----------------
  int ccnt = 0;
  logic [31:0] cq, cr;

  always @(posedge clk) begin
    if (dif.core_start) ccnt <= 1;
    else if (ccnt != 0 && ccnt < LAT) ccnt <= ccnt + 1;
  end

  always_comb begin
    cq = 32'd0;
    cr = 32'd0;
    if (dif.core_divis != 32'd0 &&
        !(dif.core_divid == 32'h8000_0000 && dif.core_divis == 32'hFFFF_FFFF)) begin
      cq = $signed(dif.core_divid) / $signed(dif.core_divis);
      cr = $signed(dif.core_divid) % $signed(dif.core_divis);
    end
  end

  // Results are garbage until the core has run its full latency.
  assign dif.core_quot   = (ccnt == LAT) ? cq : 32'hDEAD_BEEF;
  assign dif.core_rem    = (ccnt == LAT) ? cr : 32'hBADC_0FFE;
  assign dif.core_except = (ccnt == LAT) ? (dif.core_divis == 32'd0) : 1'b1;

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: divide magnitudes, then apply C-style truncation sign rules.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic e);
    longint sa, sb, ma, mb, mq, mr;
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0; e = 1'b1;
      return;
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    mq = ma / mb;
    mr = ma - mq * mb;
    q = ((sa < 0) != (sb < 0)) ? 32'(-mq) : 32'(mq);
    r = (sa < 0) ? 32'(-mr) : 32'(mr);
    e = 1'b0;
  endfunction

  // One full transaction; entered and left at a negedge with the DUT idle.
  task automatic do_txn(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input logic e,
                        input int lat, input int bp);
    int t0, t_start, n_start, waited;
    logic ops_ok, busy_ok, hold_ok;
    logic [31:0] hq, hr;
    logic he;
    dif.req_valid = 1'b1;
    dif.req_divid = a;
    dif.req_divis = b;
    dif.rsp_ready = 1'b0;
    waited = 0;
    while (!dif.req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk({nm, " accept"}, 32'(dif.req_ready), 32'd1);
    t0 = cyc;
    @(negedge clk);
    dif.req_valid = 1'b0;
    dif.req_divid = $urandom;     // operands must already be latched
    dif.req_divis = $urandom;
    n_start = 0; t_start = -1; ops_ok = 1'b1; busy_ok = 1'b1; waited = 0;
    while (!dif.rsp_valid && waited < 200) begin
      if (dif.core_start) begin
        n_start++;
        t_start = cyc - t0;
      end
      if (b != 32'd0 && (dif.core_divid !== a || dif.core_divis !== b)) ops_ok = 1'b0;
      if (!dif.busy || dif.req_ready) busy_ok = 1'b0;
      @(negedge clk);
      waited++;
    end
    chk({nm, " latency"}, 32'(cyc - t0), 32'(lat));
    chk({nm, " start_cnt"}, 32'(n_start), (b != 32'd0) ? 32'd1 : 32'd0);
    if (b != 32'd0) chk({nm, " start_at"}, 32'(t_start), 32'd1);
    chk({nm, " ops_stable"}, 32'(ops_ok), 32'd1);
    chk({nm, " busy"}, 32'(busy_ok), 32'd1);
    chk({nm, " quot"}, dif.rsp_quot, q);
    chk({nm, " rem"}, dif.rsp_rem, r);
    chk({nm, " except"}, 32'(dif.rsp_except), 32'(e));
    hq = dif.rsp_quot; hr = dif.rsp_rem; he = dif.rsp_except;
    hold_ok = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (!dif.rsp_valid || dif.rsp_quot !== hq || dif.rsp_rem !== hr ||
          dif.rsp_except !== he || !dif.busy) hold_ok = 1'b0;
    end
    if (bp > 0) chk({nm, " bp_hold"}, 32'(hold_ok), 32'd1);
    dif.rsp_ready = 1'b1;
    @(negedge clk);
    dif.rsp_ready = 1'b0;
    chk({nm, " post_valid"}, 32'(dif.rsp_valid), 32'd0);
    chk({nm, " post_busy"}, 32'(dif.busy), 32'd0);
    chk({nm, " post_ready"}, 32'(dif.req_ready), 32'd1);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, " req_ready"}, 32'(dif.req_ready), 32'd1);
    chk({nm, " busy"}, 32'(dif.busy), 32'd0);
    chk({nm, " rsp_valid"}, 32'(dif.rsp_valid), 32'd0);
    chk({nm, " core_start"}, 32'(dif.core_start), 32'd0);
    chk({nm, " core_divid"}, dif.core_divid, 32'd0);
    chk({nm, " core_divis"}, dif.core_divis, 32'd0);
    chk({nm, " rsp_quot"}, dif.rsp_quot, 32'd0);
    chk({nm, " rsp_rem"}, dif.rsp_rem, 32'd0);
    chk({nm, " rsp_except"}, 32'(dif.rsp_except), 32'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
    int          lat;
    int          bp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int waited;
    logic ready_ok, hold_ok;
    logic [31:0] ra, rb, rq, rr;
    logic re;

    tbl[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 35, 0};
    tbl[1] = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 35, 0};
    tbl[2] = '{32'd5,          32'd0,          32'd0,          32'd0,          1'b1, 1,  0};
    tbl[3] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 35, 10};
    tbl[4] = '{32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 35, 0};
    tbl[5] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 35, 2};
    tbl[6] = '{32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 35, 0};
    tbl[7] = '{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0, 35, 1};
    tbl[8] = '{32'd0,          32'd0,          32'd0,          32'd0,          1'b1, 1,  3};

    // Reset held with a pending request: reset must win.
    reset = 1'b1;
    dif.req_valid = 1'b1;
    dif.req_divid = 32'd100;
    dif.req_divis = 32'd7;
    dif.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    dif.req_valid = 1'b0;
    chk_reset_state("reset");

    for (int i = 0; i < 9; i++)
      do_txn($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
             tbl[i].e, tbl[i].lat, tbl[i].bp);

    // Second request held during WAIT: accepted on the first IDLE cycle.
    dif.req_valid = 1'b1;
    dif.req_divid = 32'd100;
    dif.req_divis = 32'd7;
    @(negedge clk);
    dif.req_divid = 32'd21;
    dif.req_divis = 32'd4;
    ready_ok = 1'b1; hold_ok = 1'b1; waited = 0;
    while (!dif.rsp_valid && waited < 200) begin
      if (dif.req_ready) ready_ok = 1'b0;
      if (dif.core_divid !== 32'd100 || dif.core_divis !== 32'd7) hold_ok = 1'b0;
      @(negedge clk);
      waited++;
    end
    chk("held ready_low", 32'(ready_ok), 32'd1);
    chk("held ops_stable", 32'(hold_ok), 32'd1);
    chk("held first_quot", dif.rsp_quot, 32'd14);
    chk("held done_ready", 32'(dif.req_ready), 32'd0);
    dif.rsp_ready = 1'b1;
    @(negedge clk);
    dif.rsp_ready = 1'b0;
    chk("held idle_ready", 32'(dif.req_ready), 32'd1);
    chk("held idle_divid", dif.core_divid, 32'd100);
    @(negedge clk);
    dif.req_valid = 1'b0;
    chk("held new_divid", dif.core_divid, 32'd21);
    chk("held new_divis", dif.core_divis, 32'd4);
    chk("held new_busy", 32'(dif.busy), 32'd1);
    waited = 0;
    while (!dif.rsp_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("held second_quot", dif.rsp_quot, 32'd5);
    chk("held second_rem", dif.rsp_rem, 32'd1);
    dif.rsp_ready = 1'b1;
    @(negedge clk);
    dif.rsp_ready = 1'b0;
    chk("held second_idle", 32'(dif.busy), 32'd0);

    // Reset in WAIT cycle 10, with a request present in the reset cycle.
    dif.req_valid = 1'b1;
    dif.req_divid = 32'd100;
    dif.req_divis = 32'd7;
    @(negedge clk);
    dif.req_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst in_wait", 32'(dif.busy), 32'd1);
    reset = 1'b1;
    dif.req_valid = 1'b1;
    dif.req_divid = 32'd55;
    dif.req_divis = 32'd3;
    @(negedge clk);
    reset = 1'b0;
    dif.req_valid = 1'b0;
    chk_reset_state("midrst");
    do_txn("post_rst", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35, 0);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = $urandom_range(0, 200);
        1:       ra = 32'd0 - $urandom_range(0, 200);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = 32'd0 - $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      ref_div(ra, rb, rq, rr, re);
      do_txn($sformatf("rnd%0d", i), ra, rb, rq, rr, re,
             (rb == 32'd0) ? 1 : LAT + 2, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
